// File: rtl/bus_seq_datapath.sv
// bus_seq_datapath: register-file datapath sequenced over a single internal bus.
// Each command runs through IDLE -> T1 -> T2 -> T3. T1 reads Ra into Y, T2 computes
// Z = ALU(Y, Rb), and T3 writes the result back.
// Define BUS_SEQ_DATAPATH_MUL_EN to build the signed multiplier and the HI/LO path.
//
// state | meaning
// IDLE  | ready for a command; fields latched on handshake
// T1    | bus = R[ra], Y <= bus
// T2    | bus = R[rb], Z <= ALU(Y, bus)
// T3    | R[rd] (or HI/LO) <= Z, done/err pulse in the next cycle
module bus_seq_datapath #(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 16,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [RW-1:0]     cmd_ra,
    input  logic [RW-1:0]     cmd_rb,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic              err,
    input  logic [RW:0]       dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int SW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t            state_q;
    logic [3:0]        op_q;
    logic [RW-1:0]     ra_q, rb_q, rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] y_q, zlo_q;
    logic [DATA_W-1:0] zlo_d;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
    logic [DATA_W-1:0] zhi_q, zhi_d;
`endif
    logic              done_q, err_q;
    logic [DATA_W-1:0] bus;
    logic              illegal;

    // The bus carries Ra during T1 and Rb otherwise; only T1 and T2 consume it.
    assign bus       = (state_q == T1) ? regs_q[ra_q] : regs_q[rb_q];
    assign cmd_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Opcode legality; opcode 9 is only legal when the multiplier is built.
    always_comb begin
        illegal = (op_q > 4'd12);
`ifndef BUS_SEQ_DATAPATH_MUL_EN
        if (op_q == 4'd9) illegal = 1'b1;
`endif
    end

    // ALU: combines Y with the bus value into the next Z.
    always_comb begin
        zlo_d = '0;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
        zhi_d = '0;
`endif
        case (op_q)
            4'd0:  zlo_d = y_q + bus;
            4'd1:  zlo_d = y_q - bus;
            4'd2:  zlo_d = y_q & bus;
            4'd3:  zlo_d = y_q | bus;
            4'd4:  zlo_d = y_q << bus[SW-1:0];
            4'd5:  zlo_d = y_q >> bus[SW-1:0];
            4'd6:  zlo_d = $signed(y_q) >>> bus[SW-1:0];
            4'd7:  zlo_d = ~y_q;
            4'd8:  zlo_d = -y_q;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
            // Sign-extend both operands so the low 2*DATA_W product bits are the signed product.
            4'd9:  {zhi_d, zlo_d} = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus[DATA_W-1]}}, bus};
`endif
            4'd10: zlo_d = imm_q;
            4'd11: zlo_d = hi_q;
            4'd12: zlo_d = lo_q;
            default: zlo_d = '0;
        endcase
    end

    // Sequencer, register file, HI/LO and the done/err pulses.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            zlo_q   <= '0;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
            zhi_q   <= '0;
`endif
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        ra_q    <= cmd_ra;
                        rb_q    <= cmd_rb;
                        rd_q    <= cmd_rd;
                        imm_q   <= cmd_imm;
                        state_q <= T1;
                    end
                end
                T1: begin
                    y_q     <= bus;
                    state_q <= T2;
                end
                T2: begin
                    zlo_q   <= zlo_d;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
                    zhi_q   <= zhi_d;
`endif
                    state_q <= T3;
                end
                T3: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    err_q   <= illegal;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
                    if (!illegal && op_q == 4'd9) begin
                        hi_q <= zhi_q;
                        lo_q <= zlo_q;
                    end
`endif
                    // R0 is hard zero, so writes to it are dropped.
                    if (!illegal && op_q != 4'd9 && rd_q != '0) regs_q[rd_q] <= zlo_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Debug read port: general registers, then HI, then LO, zero beyond.
    always_comb begin
        dbg_data = '0;
        if (!dbg_sel[RW])                     dbg_data = regs_q[dbg_sel[RW-1:0]];
        else if (dbg_sel[RW-1:0] == RW'(0))   dbg_data = hi_q;
        else if (dbg_sel[RW-1:0] == RW'(1))   dbg_data = lo_q;
    end
endmodule

// File: tb/tb_bus_seq_datapath.sv
// Bench for bus_seq_datapath: transaction-level model plus directed literal checks.
module tb_bus_seq_datapath;
    localparam int DW = 32;
`ifdef BUS_SEQ_DATAPATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Clear = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [3:0]    cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic          done, err;
    logic [4:0]    dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    bus_seq_datapath #(.DATA_W(DW), .NUM_REGS(16)) dut (
        .Clock(Clock), .Clear(Clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] m_r [16];
    logic [DW-1:0] m_hi, m_lo;
    bit            m_valid = 0, m_busy = 0, m_ready = 0, m_done = 0, m_err = 0;
    int            m_left = 0;
    logic [DW-1:0] p_res, p_hi, p_lo;
    logic [3:0]    p_rd;
    bit            p_ill, p_mul;

    function automatic logic [DW-1:0] m_dbg(input logic [4:0] s);
        if (s < 5'd16) return m_r[s[3:0]];
        if (s == 5'd16) return m_hi;
        if (s == 5'd17) return m_lo;
        return '0;
    endfunction

    always @(posedge Clock) begin
        logic [DW-1:0] a, b;
        logic [4:0]    sh;
        longint        prod;
        m_done = 0;
        m_err  = 0;
        if (Clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            m_hi = '0; m_lo = '0;
            m_busy = 0; m_ready = 1; m_valid = 1;
        end else if (m_valid && m_busy) begin
            m_left--;
            if (m_left == 0) begin
                if (!p_ill) begin
                    if (p_mul) begin m_hi = p_hi; m_lo = p_lo; end
                    else if (p_rd != 0) m_r[p_rd] = p_res;
                end
                m_busy = 0; m_ready = 1; m_done = 1; m_err = p_ill;
            end
        end else if (m_valid && cmd_valid) begin
            a = m_r[cmd_ra]; b = m_r[cmd_rb]; sh = b[4:0];
            p_ill = 0; p_mul = 0; p_res = '0; p_rd = cmd_rd;
            case (cmd_op)
                4'd0:  p_res = a + b;
                4'd1:  p_res = a - b;
                4'd2:  p_res = a & b;
                4'd3:  p_res = a | b;
                4'd4:  p_res = a << sh;
                4'd5:  p_res = a >> sh;
                4'd6:  p_res = $signed(a) >>> sh;
                4'd7:  p_res = ~a;
                4'd8:  p_res = -a;
                4'd9: begin
                    if (MUL_EN) begin
                        prod = longint'($signed(a)) * longint'($signed(b));
                        p_hi = prod[63:32]; p_lo = prod[31:0]; p_mul = 1;
                    end else p_ill = 1;
                end
                4'd10: p_res = cmd_imm;
                4'd11: p_res = m_hi;
                4'd12: p_res = m_lo;
                default: p_ill = 1;
            endcase
            m_busy = 1; m_left = 3; m_ready = 0;
        end
    end

    // Per-cycle comparison of every observable output against the model.
    always @(negedge Clock) begin
        if (m_valid) begin
            chk("cmd_ready", cmd_ready, m_ready);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("dbg_data", dbg_data, m_dbg(dbg_sel));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic [DW-1:0] imm,
                           output int lat, output logic err_seen);
        int w;
        @(posedge Clock); #1;
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm; cmd_valid = 1'b1;
        @(negedge Clock);
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge Clock); w++; end
        if (!cmd_ready) chk("handshake_timeout", cmd_ready, 1);
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge Clock);
            lat++;
        end while (!done && lat < 10);
        if (!done) chk("done_timeout", done, 1);
        err_seen = err;
    endtask

    task automatic rd_dbg(input string name, input logic [4:0] s, input logic [DW-1:0] exp);
        @(posedge Clock); #1;
        dbg_sel = s;
        @(negedge Clock);
        chk(name, dbg_data, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic e;
        logic [DW-1:0] exp_hi, exp_lo;
        logic          exp_mul_err;

        repeat (3) @(posedge Clock);
        #1 Clear = 1'b0;
        @(negedge Clock);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_done", done, 0);

        run_cmd(4'd10, 0, 0, 3, 32'h0000_0012, lat, e);
        chk("ldi_latency", lat, 4);
        rd_dbg("ldi_r3", 5'd3, 32'h12);

        run_cmd(4'd10, 0, 0, 1, 32'hFFFF_FFFF, lat, e);
        run_cmd(4'd10, 0, 0, 2, 32'h1, lat, e);
        run_cmd(4'd0, 1, 2, 4, 0, lat, e);
        rd_dbg("add_wrap_r4", 5'd4, 32'h0);
        run_cmd(4'd1, 2, 1, 5, 0, lat, e);
        rd_dbg("sub_r5", 5'd5, 32'h2);

        run_cmd(4'd10, 0, 0, 1, 32'h8000_0000, lat, e);
        run_cmd(4'd10, 0, 0, 2, 32'h21, lat, e);
        run_cmd(4'd6, 1, 2, 6, 0, lat, e);
        rd_dbg("shra_r6", 5'd6, 32'hC000_0000);
        run_cmd(4'd10, 0, 0, 0, 32'h55, lat, e);
        rd_dbg("r0_zero", 5'd0, 32'h0);

`ifdef BUS_SEQ_DATAPATH_MUL_EN
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA; exp_mul_err = 1'b0;
`else
        exp_hi = 32'h0; exp_lo = 32'h0; exp_mul_err = 1'b1;
`endif
        run_cmd(4'd10, 0, 0, 1, 32'hFFFF_FFFE, lat, e);
        run_cmd(4'd10, 0, 0, 2, 32'h3, lat, e);
        run_cmd(4'd9, 1, 2, 9, 0, lat, e);
        chk("mul_err", e, exp_mul_err);
        rd_dbg("mul_hi", 5'd16, exp_hi);
        rd_dbg("mul_lo", 5'd17, exp_lo);
        rd_dbg("mul_r9_untouched", 5'd9, 32'h0);
        run_cmd(4'd12, 0, 0, 7, 0, lat, e);
        rd_dbg("mflo_r7", 5'd7, exp_lo);

        run_cmd(4'd14, 1, 2, 3, 32'hDEAD_BEEF, lat, e);
        chk("illegal_err", e, 1);
        chk("illegal_latency", lat, 4);
        rd_dbg("illegal_r3_kept", 5'd3, 32'h12);
        rd_dbg("illegal_r6_kept", 5'd6, 32'hC000_0000);
        rd_dbg("illegal_r5_kept", 5'd5, 32'h2);

        // Clear during T2 of ADD rd=8 aborts the write and the done pulse.
        run_cmd(4'd10, 0, 0, 1, 32'h5, lat, e);
        run_cmd(4'd10, 0, 0, 2, 32'h6, lat, e);
        @(posedge Clock); #1;
        dbg_sel = 5'd8;
        cmd_op = 4'd0; cmd_ra = 1; cmd_rb = 2; cmd_rd = 8; cmd_valid = 1'b1;
        @(negedge Clock);
        chk("clr_pre_ready", cmd_ready, 1);
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        @(posedge Clock); #1;
        Clear = 1'b1;
        @(posedge Clock); #1;
        Clear = 1'b0;
        @(negedge Clock);
        chk("clr_ready_after", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("clr_no_done", done, 0);
            chk("clr_r8_zero", dbg_data, 32'h0);
        end
        chk("clr_ready_idle", cmd_ready, 1);

        // Randomized commands, checked cycle-by-cycle by the model comparison.
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [DW-1:0] imm;
            r = $urandom_range(0, 19);
            imm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
            @(posedge Clock); #1;
            dbg_sel = 5'($urandom_range(0, 31));
            run_cmd((r >= 16) ? 4'd10 : 4'(r), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), imm, lat, e);
            chk("rand_latency", lat, 4);
            repeat ($urandom_range(0, 2)) @(posedge Clock);
        end

        @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
